// File: rtl/skin_thresh_ctrl.sv
// rtl/skin_thresh_ctrl.sv - frame-synchronous skin threshold controller
// Optional feature macro: SKIN_CTRL_STATS_EN (per-frame skin pixel counter).
// Thresholds and detect enable are committed only at a vsync rising edge,
// so a frame is never classified with a mix of old and new thresholds.
module skin_thresh_ctrl #(
  parameter int CNT_W      = 22,
  parameter int RST_PRESET = 0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [3:0]       sw,
  input  logic             i_vid_vsync,
  input  logic             i_vid_VDE,
  input  logic             i_skin_hit,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_addr,
  input  logic [7:0]       cfg_data,
  output logic [7:0]       o_y_min,
  output logic [7:0]       o_cb_min,
  output logic [7:0]       o_cb_max,
  output logic [7:0]       o_cr_min,
  output logic [7:0]       o_cr_max,
  output logic             o_detect_en,
  output logic             o_cfg_err,
  output logic             o_frame_done,
  output logic [CNT_W-1:0] o_skin_count
);

  typedef enum logic [1:0] {
    WAIT_FRAME = 2'd0,
    COMMIT     = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  localparam logic [1:0] RST_IDX = RST_PRESET[1:0];

  // Packed as {y_min, cb_min, cb_max, cr_min, cr_max}
  function automatic logic [39:0] preset(input logic [1:0] idx);
    case (idx)
      2'd0:    preset = {8'd80,  8'd70, 8'd135, 8'd120, 8'd180};
      2'd1:    preset = {8'd80,  8'd85, 8'd135, 8'd135, 8'd180};
      2'd2:    preset = {8'd60,  8'd77, 8'd127, 8'd133, 8'd173};
      default: preset = {8'd100, 8'd90, 8'd125, 8'd140, 8'd170};
    endcase
  endfunction

  state_t     state;
  logic       vsync_prev;
  logic       prev_active;
  logic [7:0] sh_y_min;
  logic [7:0] sh_cb_min;
  logic [7:0] sh_cb_max;
  logic [7:0] sh_cr_min;
  logic [7:0] sh_cr_max;
  logic       vs_rise;
  logic       shadow_ok;

  // vsync_prev resets high so a vsync held through reset is not seen as an edge
  assign vs_rise   = i_vid_vsync && !vsync_prev;
  // Equal min/max would classify nothing, so it is rejected along with inverted ranges
  assign shadow_ok = (sh_cb_min < sh_cb_max) && (sh_cr_min < sh_cr_max);

`ifdef SKIN_CTRL_STATS_EN
  logic [CNT_W-1:0] counter;

  // Saturating per-frame hit counter; only live while a frame is active
  always_ff @(posedge clk) begin
    if (n_rst) begin
      counter      <= '0;
      o_skin_count <= '0;
    end else if (state == COMMIT) begin
      if (prev_active) begin
        o_skin_count <= counter;
      end
      counter <= '0;
    end else if (state == ACTIVE) begin
      if (i_vid_VDE && i_skin_hit && (counter != {CNT_W{1'b1}})) begin
        counter <= counter + 1'b1;
      end
    end
  end
`else
  logic stats_unused;

  assign stats_unused = i_vid_VDE & i_skin_hit;
  assign o_skin_count = '0;
`endif

  // Shadow bank: software writes land here, addr 5-7 acknowledged and dropped
  always_ff @(posedge clk) begin
    if (n_rst) begin
      {sh_y_min, sh_cb_min, sh_cb_max, sh_cr_min, sh_cr_max} <= preset(2'd0);
    end else if (cfg_valid && cfg_ready) begin
      case (cfg_addr)
        3'd0:    sh_y_min  <= cfg_data;
        3'd1:    sh_cb_min <= cfg_data;
        3'd2:    sh_cb_max <= cfg_data;
        3'd3:    sh_cr_min <= cfg_data;
        3'd4:    sh_cr_max <= cfg_data;
        default: ;
      endcase
    end
  end

  // Frame FSM with registered outputs; COMMIT is the single cycle where actives change
  always_ff @(posedge clk) begin
    if (n_rst) begin
      state        <= WAIT_FRAME;
      vsync_prev   <= 1'b1;
      prev_active  <= 1'b0;
      cfg_ready    <= 1'b1;
      o_detect_en  <= 1'b0;
      o_cfg_err    <= 1'b0;
      o_frame_done <= 1'b0;
      {o_y_min, o_cb_min, o_cb_max, o_cr_min, o_cr_max} <= preset(RST_IDX);
    end else begin
      vsync_prev   <= i_vid_vsync;
      o_frame_done <= 1'b0;
      case (state)
        WAIT_FRAME: begin
          if (vs_rise) begin
            state       <= COMMIT;
            cfg_ready   <= 1'b0;
            prev_active <= 1'b0;
          end
        end
        COMMIT: begin
          state       <= ACTIVE;
          cfg_ready   <= 1'b1;
          o_detect_en <= !sw[2];
          if (!sw[3]) begin
            {o_y_min, o_cb_min, o_cb_max, o_cr_min, o_cr_max} <= preset(sw[1:0]);
            o_cfg_err <= 1'b0;
          end else if (shadow_ok) begin
            {o_y_min, o_cb_min, o_cb_max, o_cr_min, o_cr_max} <=
              {sh_y_min, sh_cb_min, sh_cb_max, sh_cr_min, sh_cr_max};
            o_cfg_err <= 1'b0;
          end else begin
            o_cfg_err <= 1'b1;
          end
          if (prev_active) begin
            o_frame_done <= 1'b1;
          end
        end
        ACTIVE: begin
          if (vs_rise) begin
            state       <= COMMIT;
            cfg_ready   <= 1'b0;
            prev_active <= 1'b1;
          end
        end
        default: begin
          state     <= WAIT_FRAME;
          cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/skin_thresh_ctrl.md
Name: skin_thresh_ctrl

Overview:
- Frame-synchronous threshold controller for the YCbCr skin-detection datapath.
- Holds a runtime-writable shadow threshold bank and a fixed preset table, and selects the source with sw.
- Commits the thresholds and detection enable to the detector only at a vsync rising edge, so a frame never uses mixed thresholds.
- Counts skin-classified pixels per frame for software readback.

Parameters:
CNT_W, 22, skin pixel counter width (1920x1080 = 2,073,600 < 2^22)
RST_PRESET, 0, preset index loaded into active thresholds at reset

Ports:
clk  input  1  system clock
n_rst  input  1  synchronous reset, active-high (1 = reset; name kept per codebase)
sw  input  4  [1:0] preset index, [2] bypass (detect off), [3] 1 = use shadow bank
i_vid_vsync  input  1  video vsync, active high
i_vid_VDE  input  1  video data enable
i_skin_hit  input  1  detector classification, qualified by i_vid_VDE
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accept
cfg_addr  input  3  0 y_min, 1 cb_min, 2 cb_max, 3 cr_min, 4 cr_max, 5-7 reserved
cfg_data  input  8  config write data
o_y_min, o_cb_min, o_cb_max, o_cr_min, o_cr_max  output  8 each  active thresholds
o_detect_en  output  1  1 = detector applies thresholds, 0 = pass video unmodified
o_cfg_err  output  1  sticky: last shadow commit rejected
o_frame_done  output  1  1-cycle pulse: o_skin_count updated
o_skin_count  output  CNT_W  skin pixel count of last complete frame

Behaviour:
- Preset table (y_min, cb_min, cb_max, cr_min, cr_max):
  - 0: 80, 70, 135, 120, 180
  - 1: 80, 85, 135, 135, 180
  - 2: 60, 77, 127, 133, 173
  - 3: 100, 90, 125, 140, 170
- Reset values:
  - Active thresholds = preset RST_PRESET; shadow bank = preset 0.
  - o_detect_en = 0, o_cfg_err = 0, o_frame_done = 0, o_skin_count = 0, counter = 0.
  - cfg_ready = 1; state WAIT_FRAME; vsync_prev = 1.
- Config handshake:
  - A write transfers when cfg_valid && cfg_ready; the shadow register updates at that clock edge.
  - cfg_valid may stay high across cfg_ready = 0; the write completes when ready returns.
  - Addr 5-7 writes are acknowledged and discarded.
  - cfg_ready = 0 only in COMMIT.
- Edge detect: vs_rise = i_vid_vsync && !vsync_prev, registered every cycle. vsync_prev resets to 1, so vsync held high through reset is not an edge.
- FSM states:
  - WAIT_FRAME: after reset. Counter idle, o_detect_en = 0. vs_rise -> COMMIT.
  - COMMIT: exactly 1 cycle, then -> ACTIVE. In this cycle:
    - sw is sampled.
    - If sw[3] = 0: active = preset[sw[1:0]], o_cfg_err cleared.
    - If sw[3] = 1 and shadow cb_min < cb_max and cr_min < cr_max: active = shadow, o_cfg_err cleared.
    - Otherwise: active unchanged, o_cfg_err = 1.
    - o_detect_en = !sw[2].
    - If previous state was ACTIVE: o_skin_count = counter, o_frame_done pulses, counter cleared.
  - ACTIVE: counter += 1 when i_vid_VDE && i_skin_hit; saturates at 2^CNT_W-1. vs_rise -> COMMIT.
- Timing:
  - Active outputs change 2 cycles after the vsync rising edge: 1 edge register + 1 COMMIT.
  - They are stable for the whole frame otherwise.
  - sw changes mid-frame have no effect until the next commit.
- Simultaneous events:
  - A cfg write accepted in the vs_rise cycle is visible to that commit.
  - A hit in the vs_rise cycle is counted in the closing frame.
  - The COMMIT cycle itself counts nothing (it is vsync time, VDE = 0).
- n_rst mid-frame: immediate return to reset values next edge; in-progress count discarded, no o_frame_done.
- Widths: all thresholds unsigned 8-bit; comparisons for validation unsigned; equality (min == max) is rejected.

Optional Feature:
SKIN_CTRL_STATS_EN
- Defined: counter, o_skin_count and o_frame_done operate as above.
- Undefined: no counter logic; o_skin_count tied 0; o_frame_done still pulses in COMMIT when the previous state was ACTIVE (frame tick kept for software).

Test Plan:
- Reset with sw = 0, vsync high -> thresholds 80/70/135/120/180, o_detect_en = 0; vsync stays high 10 cycles -> no COMMIT.
- vsync 0→1 with sw = 4'b0001 -> 2 cycles later outputs 80/85/135/135/180, o_detect_en = 1, cfg_ready low exactly 1 cycle, no o_frame_done (first frame).
- sw = 4'b1000, writes (1,100), (2,130), (3,140), (4,175), (0,90), next vsync rise -> outputs 90/100/130/140/175, o_cfg_err = 0.
- Shadow cb_min = 130, cb_max = 130, sw[3] = 1, vsync rise -> outputs unchanged, o_cfg_err = 1; then sw = 0 and vsync rise -> preset 0 applied, o_cfg_err = 0.
- ACTIVE frame with 1000 cycles VDE = 1, hit on 37 of them, then vsync rise -> o_skin_count = 37 and o_frame_done pulse 2 cycles after the edge; next frame 0 hits -> 0.
- cfg write held valid across the COMMIT cycle -> accepted the cycle after COMMIT; n_rst pulse mid-frame with 500 hits counted -> o_skin_count = 0, state WAIT_FRAME, no frame_done.
